serial_comp_scheduler: RTL



---
 rtl/serial_comp_pkg.sv | 12 +
 rtl/serial_comp_scheduler_if.sv | 28 ++
 rtl/serial_comp_core.sv | 42 ++++
 rtl/serial_comp_scheduler.sv | 100 ++++++++++
 4 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the bit-serial two's-complement scheduler.
package serial_comp_pkg;

   localparam int unsigned LAB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_comp_scheduler_if.sv
// Request/result bus between the two requesters, the consumer and the scheduler.
interface serial_comp_scheduler_if
   import serial_comp_pkg::*;
#(
   parameter int unsigned W = LAB_W
);

   logic [1:0]   req;
   logic [W-1:0] din0;
   logic [W-1:0] din1;
   logic [1:0]   ack;
   logic         busy;
   logic         res_valid;
   logic [W-1:0] res_data;
   logic         res_id;
   logic         res_ready;

   modport master (
      output req, din0, din1, res_ready,
      input  ack, busy, res_valid, res_data, res_id
   );

   modport slave (
      input  req, din0, din1, res_ready,
      output ack, busy, res_valid, res_data, res_id
   );

endinterface

// File: rtl/serial_comp_core.sv
// Bit-serial Mealy two's complement: LSB-first shift register plus a seen-a-one flag.
module serial_comp_core
   import serial_comp_pkg::*;
#(
   parameter int unsigned W = LAB_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic [W-1:0] sr,
   output logic         last_step
);

   localparam int unsigned CW = $clog2(W + 1);

   logic          a_flag;
   logic [CW-1:0] count;
   logic          v_c;

   // Bits up to and including the first one pass through; later bits are inverted.
   assign v_c       = sr[0] ^ a_flag;
   assign last_step = (count == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr     <= '0;
         a_flag <= 1'b0;
         count  <= '0;
      end else if (load) begin
         sr     <= din;
         a_flag <= 1'b0;
         count  <= '0;
      end else if (shift) begin
         sr     <= {v_c, sr[W-1:1]};
         a_flag <= a_flag | sr[0];
         count  <= count + CW'(1);
      end
   end

endmodule

// File: rtl/serial_comp_scheduler.sv
// Round-robin arbiter and sequencer sharing one serial complement unit between two requesters.
module serial_comp_scheduler
   import serial_comp_pkg::*;
#(
   parameter int unsigned W = LAB_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_comp_scheduler_if.slave  bus
);

   state_t       state;
   logic         last;
   logic         busy_q;
   logic         res_valid_q;
   logic         res_id_q;
   logic         winner_c;
   logic         any_req_c;
   logic         load_c;
   logic         shift_c;
   logic [W-1:0] din_sel_c;
   logic [W-1:0] sr;
   logic         last_step;

   // On a tie the requester that was not served last wins; reset leaves last=1.
   always_comb begin
      winner_c = bus.req[1];
      if (bus.req == 2'b11) begin
         winner_c = ~last;
      end
   end

   assign any_req_c = |bus.req;
   assign load_c    = (state == ST_IDLE) && any_req_c;
   assign shift_c   = (state == ST_SHIFT);
   assign din_sel_c = winner_c ? bus.din1 : bus.din0;

   // ack is combinational and forced low while reset is held.
   always_comb begin
      bus.ack = 2'b00;
      if (rst_n && load_c) begin
         bus.ack = winner_c ? 2'b10 : 2'b01;
      end
   end

   serial_comp_core #(.W(W)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c),
      .shift     (shift_c),
      .din       (din_sel_c),
      .sr        (sr),
      .last_step (last_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         last        <= 1'b1;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req_c) begin
                  state    <= ST_SHIFT;
                  busy_q   <= 1'b1;
                  res_id_q <= winner_c;
                  last     <= winner_c;
               end
            end
            ST_SHIFT: begin
               if (last_step) begin
                  state       <= ST_DONE;
                  res_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  state       <= ST_IDLE;
                  busy_q      <= 1'b0;
                  res_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_data  = sr;

endmodule
